// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: mid-bit sampled start/data/parity/stop
// bits, delivered through a valid/ready holding register with parity, framing and overrun flags.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_d_in,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] d_out_rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 ovr_q, ovr_d;
    logic                 rxs, half_hit, full_hit, frame_done, pbit_xor;

    // NOTE: the synchroniser resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx_d_in};
    end

    assign rxs      = sync_q[1];
    assign half_hit = sample_tick && (tick_cnt_q == HALF_LAST);
    assign full_hit = sample_tick && (tick_cnt_q == FULL_LAST);
    assign pbit_xor = (^shift_q) ^ rxs;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            ovr_q      <= ovr_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        frame_done = 1'b0;
        if (sample_tick && state_q != S_IDLE) tick_cnt_d = tick_cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (sample_tick && !rxs) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            S_START: begin
                if (half_hit) begin
                    tick_cnt_d = '0;
                    state_d    = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (full_hit) begin
                    tick_cnt_d = '0;
                    shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (full_hit) begin
                    tick_cnt_d = '0;
                    perr_acc_d = (PARITY_MODE == 2) ? ~pbit_xor : pbit_xor;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (full_hit) begin
                    tick_cnt_d = '0;
                    if (!rxs) ferr_acc_d = 1'b1;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d  = '0;
                        state_d    = S_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A completing frame may replace the held word only if it is free or being read this cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        ovr_d     = 1'b0;
        if (frame_done) begin
            if (!valid_q || rx_ready) begin
                data_d    = shift_q;
                valid_d   = 1'b1;
                par_err_d = perr_acc_q;
                frm_err_d = ferr_acc_d;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    assign d_out_rx    = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = par_err_q;
    assign frame_err   = frm_err_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four receivers (8N1, 8E1, 8O1, 7N2) at 16x oversampling,
// each on its own serial line, with a tick every 4 clk (one bit = 64 clk).
module tb_uart_rx_param;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx_line[4];
    logic       ready[4];
    logic       valid[4], perr[4], ferr[4], ovr[4], busy[4];
    logic [7:0] dout0, dout1, dout2;
    logic [6:0] dout3;
    logic [8:0] dout_w[4];

    int         tests = 0;
    int         fails = 0;
    int         acc_cnt[4] = '{default: 0};
    int         ovr_cnt[4] = '{default: 0};
    logic [8:0] last_data[4] = '{default: '0};
    logic       last_perr[4] = '{default: 1'b0};
    logic       last_ferr[4] = '{default: 1'b0};

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
        .clk(clk), .rst(rst), .rx_d_in(rx_line[0]), .sample_tick(sample_tick),
        .d_out_rx(dout0), .rx_valid(valid[0]), .rx_ready(ready[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .overrun_err(ovr[0]), .busy(busy[0]));
    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_8e1 (
        .clk(clk), .rst(rst), .rx_d_in(rx_line[1]), .sample_tick(sample_tick),
        .d_out_rx(dout1), .rx_valid(valid[1]), .rx_ready(ready[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .overrun_err(ovr[1]), .busy(busy[1]));
    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_8o1 (
        .clk(clk), .rst(rst), .rx_d_in(rx_line[2]), .sample_tick(sample_tick),
        .d_out_rx(dout2), .rx_valid(valid[2]), .rx_ready(ready[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .overrun_err(ovr[2]), .busy(busy[2]));
    uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(16)) u_7n2 (
        .clk(clk), .rst(rst), .rx_d_in(rx_line[3]), .sample_tick(sample_tick),
        .d_out_rx(dout3), .rx_valid(valid[3]), .rx_ready(ready[3]), .parity_err(perr[3]),
        .frame_err(ferr[3]), .overrun_err(ovr[3]), .busy(busy[3]));

    assign dout_w[0] = {1'b0, dout0};
    assign dout_w[1] = {1'b0, dout1};
    assign dout_w[2] = {1'b0, dout2};
    assign dout_w[3] = {2'b00, dout3};

    always #5 clk = ~clk;

    // Tick rises on a negedge and is seen by exactly one posedge, every 4 clk.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    // Records every accepted word and every overrun pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                if (valid[i] && ready[i]) begin
                    acc_cnt[i]   = acc_cnt[i] + 1;
                    last_data[i] = dout_w[i];
                    last_perr[i] = perr[i];
                    last_ferr[i] = ferr[i];
                end
                if (ovr[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int idx, input logic b);
        rx_line[idx] = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input logic [8:0] data, input int dbits,
                              input int npar, input logic pbit, input int nstop,
                              input logic [1:0] stops);
        drive_bit(idx, 1'b0);
        for (int i = 0; i < dbits; i++) drive_bit(idx, data[i]);
        if (npar != 0) drive_bit(idx, pbit);
        for (int i = 0; i < nstop; i++) drive_bit(idx, stops[i]);
        rx_line[idx] = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rx_line[i] = 1'b1;
            ready[i]   = 1'b1;
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_data", 32'(dout0), 32'h00);
        check("rst_perr", 32'(perr[0]), 32'd0);
        check("rst_ferr", 32'(ferr[0]), 32'd0);
        check("rst_ovr", 32'(ovr[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 basic word
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
        check("8n1_count", 32'(acc_cnt[0]), 32'd1);
        check("8n1_data", 32'(last_data[0]), 32'hA5);
        check("8n1_perr", 32'(last_perr[0]), 32'd0);
        check("8n1_ferr", 32'(last_ferr[0]), 32'd0);
        check("8n1_idle", 32'(busy[0]), 32'd0);
        check("8n1_valid_1clk", 32'(valid[0]), 32'd0);

        // 0x3C has four ones: even parity bit is 0, odd parity bit is 1
        send_frame(1, 9'h03C, 8, 1, 1'b1, 1, 2'b11);
        check("even_bad_data", 32'(last_data[1]), 32'h3C);
        check("even_bad_perr", 32'(last_perr[1]), 32'd1);
        send_frame(1, 9'h03C, 8, 1, 1'b0, 1, 2'b11);
        check("even_good_perr", 32'(last_perr[1]), 32'd0);
        check("even_count", 32'(acc_cnt[1]), 32'd2);
        send_frame(2, 9'h03C, 8, 1, 1'b0, 1, 2'b11);
        check("odd_bad_data", 32'(last_data[2]), 32'h3C);
        check("odd_bad_perr", 32'(last_perr[2]), 32'd1);
        send_frame(2, 9'h03C, 8, 1, 1'b1, 1, 2'b11);
        check("odd_good_perr", 32'(last_perr[2]), 32'd0);
        check("odd_good_ferr", 32'(last_ferr[2]), 32'd0);

        // 4-tick low glitch is rejected at the start-bit centre
        rx_line[0] = 1'b0;
        repeat (16) @(negedge clk);
        check("glitch_busy", 32'(busy[0]), 32'd1);
        rx_line[0] = 1'b1;
        repeat (24) @(negedge clk);
        check("glitch_idle", 32'(busy[0]), 32'd0);
        repeat (BIT_CLKS) @(negedge clk);
        check("glitch_nothing", 32'(acc_cnt[0]), 32'd1);
        send_frame(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
        check("post_glitch_data", 32'(last_data[0]), 32'h5A);
        check("post_glitch_count", 32'(acc_cnt[0]), 32'd2);

        // 7N2 with the second stop bit low
        send_frame(3, 9'h055, 7, 0, 1'b0, 2, 2'b01);
        check("7n2_data", 32'(last_data[3]), 32'h55);
        check("7n2_ferr", 32'(last_ferr[3]), 32'd1);
        send_frame(3, 9'h02A, 7, 0, 1'b0, 2, 2'b11);
        check("7n2_clean_data", 32'(last_data[3]), 32'h2A);
        check("7n2_clean_ferr", 32'(last_ferr[3]), 32'd0);
        check("7n2_count", 32'(acc_cnt[3]), 32'd2);

        // Overrun: second word dropped while the first is held
        ready[0] = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, 2'b11);
        check("hold_valid", 32'(valid[0]), 32'd1);
        check("hold_data", 32'(dout0), 32'h11);
        send_frame(0, 9'h022, 8, 0, 1'b0, 1, 2'b11);
        check("ovr_data_kept", 32'(dout0), 32'h11);
        check("ovr_pulses", 32'(ovr_cnt[0]), 32'd1);

        // Start bit aligned to a tick: detection is 1 tick later, and the final stop
        // sample lands on tick 16*10-8 = 152 after detection, i.e. the 153rd tick from now.
        @(posedge sample_tick);
        fork
            send_frame(0, 9'h033, 8, 0, 1'b0, 1, 2'b11);
            begin
                repeat (153) @(posedge sample_tick);
                ready[0] = 1'b1;
                @(negedge clk);
                ready[0] = 1'b0;
            end
        join
        check("swap_data", 32'(dout0), 32'h33);
        check("swap_valid", 32'(valid[0]), 32'd1);
        check("swap_no_ovr", 32'(ovr_cnt[0]), 32'd1);
        check("swap_accept_old", 32'(acc_cnt[0]), 32'd3);
        ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("drain_valid", 32'(valid[0]), 32'd0);
        check("drain_data", 32'(last_data[0]), 32'h33);

        // Reset in the middle of the 4th data bit
        fork
            send_frame(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b11);
            begin
                repeat (4 * BIT_CLKS + 32) @(negedge clk);
                check("mid_busy", 32'(busy[0]), 32'd1);
                rst = 1'b0;
                #1;
                check("mid_rst_busy", 32'(busy[0]), 32'd0);
                check("mid_rst_data", 32'(dout0), 32'h00);
                check("mid_rst_valid", 32'(valid[0]), 32'd0);
            end
        join
        rst = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b11);
        check("after_rst_data", 32'(last_data[0]), 32'hC3);
        check("after_rst_count", 32'(acc_cnt[0]), 32'd5);
        check("after_rst_ferr", 32'(last_ferr[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
